// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch port and
// a data port. One transaction is in flight at a time. Each transaction runs
// IDLE -> BUSY -> DONE. It finishes when memory acknowledges, or it is
// aborted after TIMEOUT busy cycles with no acknowledge.
//
// Optional build macro: MEM_ARBITER_ROUND_ROBIN_EN
//   defined   : simultaneous requests alternate. The first tie after reset
//               goes to data.
//   undefined : data always wins a tie (fixed priority).
//
// Ports
//   clk, rst                 system clock; asynchronous active-low reset
//   if_req/if_addr           fetch request and address (request held until if_done)
//   if_rdata/if_done         fetched word; one-cycle completion pulse
//   if_stall                 if_req & ~if_done
//   d_req/d_we/d_size/
//   d_sign_ext/d_addr/d_wdata data request, held until d_done
//   d_rdata/d_done           load result; one-cycle completion pulse
//   d_stall                  d_req & ~d_done
//   mem_req/mem_we/mem_size/
//   mem_sign_ext/mem_addr/
//   mem_wdata                registered memory request, stable while busy
//   mem_rdata/mem_ack        memory read data and completion
//   timeout_err              sticky flag: a transaction was aborted
//
// FSM states
//   state | meaning
//   IDLE  | no transaction; the next request is arbitrated and latched
//   BUSY  | mem_req high, waiting for mem_ack or the timeout
//   DONE  | one cycle; owner's done pulses, requests are ignored
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_sign_ext,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic        mem_sign_ext,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q;          // 1 = data port owns the transaction
    logic [CNT_W-1:0] cnt_q;
    logic             any_req;
    logic             grant_data;
    logic             timeout_hit;

    assign any_req     = if_req | d_req;
    assign timeout_hit = (cnt_q == CNT_TC);
    assign if_stall    = if_req & ~if_done;
    assign d_stall     = d_req & ~d_done;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_owner_q;                 // 1 = data port was granted last

    // On a tie, grant the port that was not granted last time.
    assign grant_data = d_req & (~if_req | ~last_owner_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= 1'b0;
        end else if (state_q == IDLE && any_req) begin
            last_owner_q <= grant_data;
        end
    end
`else
    assign grant_data = d_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (mem_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_size     <= 2'b00;
            mem_sign_ext <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            if_rdata     <= 32'h0;
            d_rdata      <= 32'h0;
            if_done      <= 1'b0;
            d_done       <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= grant_data;
                        cnt_q   <= '0;
                        mem_req <= 1'b1;
                        if (grant_data) begin
                            mem_we       <= d_we;
                            mem_size     <= d_size;
                            mem_sign_ext <= d_sign_ext;
                            mem_addr     <= d_addr;
                            mem_wdata    <= d_wdata;
                        end else begin
                            // Fetches are always full-word reads.
                            mem_we       <= 1'b0;
                            mem_size     <= 2'b10;
                            mem_sign_ext <= 1'b0;
                            mem_addr     <= if_addr;
                            mem_wdata    <= 32'h0;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // An acknowledge in the timeout cycle still completes normally.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (owner_q) begin
                            d_done <= 1'b1;
                            if (!mem_we) d_rdata <= mem_rdata;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        mem_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        if (owner_q) begin
                            d_done <= 1'b1;
                            if (!mem_we) d_rdata <= 32'h0;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= 32'h0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
